// File: rtl/mux_41_arb_pkg.sv
// mux_41_arb_pkg: shared constants and state encoding for the mux_41 arbiter
package mux_41_arb_pkg;
    localparam int N_REQ            = 4;
    localparam int MAX_HOLD_DEFAULT = 8;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
endpackage

// File: rtl/mux_41_arbiter_rr_pick.sv
// rr_pick: rotating first-set search over masked requests starting at ptr
module rr_pick
    import mux_41_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             valid,
    output logic [1:0]       idx
);
    logic [N_REQ-1:0] cand;
    // Scan from the farthest slot back towards ptr so the slot nearest ptr wins
    always_comb begin
        cand  = req & mask;
        valid = |cand;
        idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (cand[ptr + 2'(k)]) idx = ptr + 2'(k);
    end
endmodule

// File: rtl/mux_41_arbiter.sv
// mux_41_arbiter: round-robin owner of a shared 4:1 mux with bounded hold time
module mux_41_arbiter
    import mux_41_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             s00,
    output logic             s01,
    output logic             s1,
    output logic             busy
);
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d, ptr_q, ptr_d, sel_q, sel_d, pick_idx, win;
    logic [3:0]       hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, mask;
    logic             busy_q, pick_valid, rel, take;
    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );
    // Release/handoff decision; the releasing owner is masked out and only re-granted when nobody else asks
    always_comb begin
        rel     = state_q == GRANT && (!req[owner_q] || hold_q == HOLD_LAST);
        mask    = state_q == GRANT ? ~(N_REQ'(1) << owner_q) : '1;
        take    = state_q == IDLE ? pick_valid : rel && (pick_valid || req[owner_q]);
        win     = pick_valid ? pick_idx : owner_q;
        state_d = (take || (state_q == GRANT && !rel)) ? GRANT : IDLE;
        owner_d = take ? win : owner_q;
        ptr_d   = take ? win + 2'd1 : ptr_q;
        hold_d  = (take || state_d == IDLE) ? '0 : hold_q + 4'd1;
        sel_d   = take ? win : sel_q;
        gnt_d   = state_d == GRANT ? N_REQ'(1) << owner_d : '0;
    end
    // All state and outputs update together; reset clears them without waiting for clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= state_d == GRANT;
        end
    end
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign s1   = sel_q[1];
    assign s00  = sel_q[0];
    assign s01  = sel_q[0];
endmodule

// File: tb/tb_mux_41_arbiter.sv
// tb_mux_41_arbiter: directed and random checks of the mux_41 arbiter against a rule-level model
module tb_mux_41_arbiter;
    localparam int MH = 8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0;
    logic [3:0] gnt;
    logic       s00, s01, s1, busy;
    logic [7:0] dat [4];
    logic [7:0] y;
    int n_cmp = 0;
    int n_bad = 0;
    int m_own, m_cnt, m_ptr, m_last;

    always #5 clk = ~clk;

    mux_41_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .s00(s00), .s01(s01), .s1(s1), .busy(busy)
    );

    // the shared mux_41: first stage picks within a/b and c/d, second stage between pairs
    assign y = s1 ? (s01 ? dat[3] : dat[2]) : (s00 ? dat[1] : dat[0]);

    function automatic void model_reset();
        m_own = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
    endfunction

    // one clock edge of the arbitration rules, with req value r sampled
    function automatic void advance(input logic [3:0] r);
        int nxt = -1;
        bit rel = (m_own < 0) || !r[m_own] || m_cnt == MH - 1;
        if (!rel) begin
            m_cnt++;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            int j = (m_ptr + k) % 4;
            if (nxt < 0 && r[j] && j != m_own) nxt = j;
        end
        if (nxt < 0 && m_own >= 0 && r[m_own]) nxt = m_own;
        if (nxt >= 0) begin
            m_own = nxt; m_cnt = 0; m_ptr = (nxt + 1) % 4; m_last = nxt;
        end else
            m_own = -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        return m_own < 0 ? 4'b0 : 4'(1 << m_own);
    endfunction

    function automatic logic [2:0] exp_sel();
        logic [1:0] l = 2'(m_last);
        return {l[1], l[0], l[0]};
    endfunction

    task automatic step(input logic [3:0] r);
        req = r;
        foreach (dat[i]) dat[i] = 8'($urandom);
        @(posedge clk);
        advance(r);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0;
        #12;
        n_cmp++;
        if (gnt !== 4'b0 || busy !== 1'b0 || {s1, s01, s00} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset: gnt=%b busy=%b sel=%b, need 0000/0/000", gnt, busy, {s1, s01, s00});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            step(4'b0001);
            n_cmp++;
            if (gnt !== 4'b0001 || busy !== 1'b1 || {s1, s01, s00} !== 3'b000 || exp_gnt() !== 4'b0001) begin
                n_bad++;
                $display("FAIL single cyc %0d: gnt=%b busy=%b sel=%b, need 0001/1/000", i, gnt, busy, {s1, s01, s00});
            end
            n_cmp++;
            if (y !== dat[0]) begin
                n_bad++;
                $display("FAIL single_y cyc %0d: y=%h need %h", i, y, dat[0]);
            end
        end
    endtask

    task automatic test_idle();
        step(4'b1000);
        n_cmp++;
        if (gnt !== 4'b1000 || {s1, s01, s00} !== 3'b111) begin
            n_bad++;
            $display("FAIL idle_pre: gnt=%b sel=%b, need 1000/111", gnt, {s1, s01, s00});
        end
        for (int i = 0; i < 3; i++) begin
            step(4'b0000);
            n_cmp++;
            if (gnt !== 4'b0 || busy !== 1'b0 || {s1, s01, s00} !== 3'b111 || exp_gnt() !== 4'b0) begin
                n_bad++;
                $display("FAIL idle cyc %0d: gnt=%b busy=%b sel=%b, need 0000/0/111", i, gnt, busy, {s1, s01, s00});
            end
        end
    endtask

    task automatic test_all_req();
        logic [3:0] want;
        apply_reset();
        for (int i = 1; i <= 40; i++) begin
            step(4'b1111);
            want = 4'(1 << (((i - 1) / MH) % 4));
            n_cmp++;
            if (gnt !== want || gnt !== exp_gnt() || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL all_req cyc %0d: gnt=%b busy=%b, need %b/1", i, gnt, busy, want);
            end
            n_cmp++;
            if (y !== dat[m_own]) begin
                n_bad++;
                $display("FAIL all_req_y cyc %0d: y=%h need %h", i, y, dat[m_own]);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 1; i <= 3; i++) begin
            step(4'b0100);
            n_cmp++;
            if (gnt !== 4'b0100 || {s1, s01, s00} !== 3'b100) begin
                n_bad++;
                $display("FAIL wrap_own2 cyc %0d: gnt=%b sel=%b, need 0100/100", i, gnt, {s1, s01, s00});
            end
        end
        for (int i = 1; i <= 3; i++) begin
            step(4'b0010);
            n_cmp++;
            if (gnt !== 4'b0010 || busy !== 1'b1 || {s1, s01, s00} !== 3'b011 || exp_gnt() !== 4'b0010) begin
                n_bad++;
                $display("FAIL wrap_own1 cyc %0d: gnt=%b busy=%b sel=%b, need 0010/1/011", i, gnt, busy, {s1, s01, s00});
            end
            n_cmp++;
            if (y !== dat[1]) begin
                n_bad++;
                $display("FAIL wrap_y cyc %0d: y=%h need %h", i, y, dat[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(4'b1000);
        step(4'b1000);
        n_cmp++;
        if (gnt !== 4'b1000) begin
            n_bad++;
            $display("FAIL async_pre: gnt=%b need 1000", gnt);
        end
        #1;
        rst = 1'b1;
        req = 4'b0;
        #1;
        n_cmp++;
        if (gnt !== 4'b0 || busy !== 1'b0 || {s1, s01, s00} !== 3'b0) begin
            n_bad++;
            $display("FAIL async_mid: gnt=%b busy=%b sel=%b, need 0000/0/000", gnt, busy, {s1, s01, s00});
        end
        #2;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        step(4'b1000);
        n_cmp++;
        if (gnt !== 4'b1000 || busy !== 1'b1 || {s1, s01, s00} !== 3'b111) begin
            n_bad++;
            $display("FAIL async_post: gnt=%b busy=%b sel=%b, need 1000/1/111", gnt, busy, {s1, s01, s00});
        end
    endtask

    task automatic test_random();
        logic [3:0] r = 4'($urandom);
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r);
            n_cmp++;
            if (gnt !== exp_gnt() || busy !== (m_own >= 0) || {s1, s01, s00} !== exp_sel() || !$onehot0(gnt)) begin
                n_bad++;
                $display("FAIL random cyc %0d req=%b: gnt=%b busy=%b sel=%b, need %b/%0d/%b",
                         i, r, gnt, busy, {s1, s01, s00}, exp_gnt(), m_own >= 0, exp_sel());
            end
            if (m_own >= 0) begin
                n_cmp++;
                if (y !== dat[m_own]) begin
                    n_bad++;
                    $display("FAIL random_y cyc %0d: y=%h need %h", i, y, dat[m_own]);
                end
            end
        end
    endtask

    initial begin
        foreach (dat[i]) dat[i] = 8'h0;
        model_reset();
        test_reset();
        test_single();
        test_idle();
        test_all_req();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
